// File: rtl/sensor_noc_pkg.sv
// Shared definitions for the sensor-event NoC path: flit layout, flit type code
// and the packetizer state encoding.
package sensor_noc_pkg;

    localparam int FLIT_W        = 32;
    localparam int FLIT_TYPE_LSB = 28;
    localparam int FLIT_TYPE_W   = 4;
    localparam int FLIT_NODE_LSB = 20;
    localparam int FLIT_NODE_W   = 8;
    localparam int FLIT_SRC_LSB  = 16;
    localparam int FLIT_SRC_W    = 4;
    localparam int FLIT_TS_LSB   = 0;
    localparam int FLIT_TS_W     = 16;

    localparam logic [FLIT_TYPE_W-1:0] FLIT_TYPE_SENSOR_EVT = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_CLEAR = 2'd2
    } pkt_state_e;

    function automatic logic [FLIT_W-1:0] pack_sensor_flit(
        input logic [FLIT_NODE_W-1:0] node,
        input logic [FLIT_SRC_W-1:0]  src,
        input logic [FLIT_TS_W-1:0]   ts
    );
        logic [FLIT_W-1:0] flit;
        flit = '0;
        flit[FLIT_TYPE_LSB +: FLIT_TYPE_W] = FLIT_TYPE_SENSOR_EVT;
        flit[FLIT_NODE_LSB +: FLIT_NODE_W] = node;
        flit[FLIT_SRC_LSB  +: FLIT_SRC_W]  = src;
        flit[FLIT_TS_LSB   +: FLIT_TS_W]   = ts;
        return flit;
    endfunction

endpackage

// File: rtl/fixed_prio_encoder.sv
// Combinational fixed-priority encoder: reports whether any request is set and
// the index of the lowest set request.
module fixed_prio_encoder #(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [3:0]       idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 4'(i);
            end else begin
                valid = valid;
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/sensor_irq_packetizer.sv
// Serves latched sensor interrupts in fixed priority order: one sensor-event flit
// per interrupt over valid/ready, followed by a one-cycle clear to that source.
module sensor_irq_packetizer
    import sensor_noc_pkg::*;
#(
    parameter int         N_SRC   = 8,
    parameter logic [7:0] NODE_ID = 8'h00,
    parameter int         TS_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq,
    input  logic [N_SRC-1:0] irq_mask,
    output logic [N_SRC-1:0] irq_clr,
    output logic             flit_valid,
    input  logic             flit_ready,
    output logic [31:0]      flit_data,
    output logic             busy
);

    pkt_state_e        state_r;
    logic [TS_W-1:0]   ts_r;
    logic [N_SRC-1:0]  sel_r;
    logic [N_SRC-1:0]  irq_clr_r;
    logic              flit_valid_r;
    logic [31:0]       flit_data_r;
    logic              busy_r;

    logic [N_SRC-1:0]  cand_s;
    logic              win_valid_s;
    logic [3:0]        win_idx_s;

    assign cand_s = irq & ~irq_mask;

    fixed_prio_encoder #(
        .N_SRC (N_SRC)
    ) u_prio (
        .req   (cand_s),
        .valid (win_valid_s),
        .idx   (win_idx_s)
    );

    // Free-running timestamp, wraps naturally at its width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_r <= '0;
        end else begin
            ts_r <= ts_r + {{(TS_W-1){1'b0}}, 1'b1};
        end
    end

    // Packetizer FSM; the winner's one-hot clear mask is captured with the flit so
    // later irq/mask changes cannot redirect the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            sel_r        <= '0;
            irq_clr_r    <= '0;
            flit_valid_r <= 1'b0;
            flit_data_r  <= 32'h0000_0000;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        flit_data_r  <= pack_sensor_flit(NODE_ID, win_idx_s, ts_r[FLIT_TS_W-1:0]);
                        sel_r        <= N_SRC'(1) << win_idx_s;
                        flit_valid_r <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ST_SEND;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (flit_ready) begin
                        flit_valid_r <= 1'b0;
                        irq_clr_r    <= sel_r;
                        state_r      <= ST_CLEAR;
                    end else begin
                        state_r      <= ST_SEND;
                    end
                end
                ST_CLEAR: begin
                    irq_clr_r <= '0;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    irq_clr_r    <= '0;
                    flit_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign irq_clr    = irq_clr_r;
    assign flit_valid = flit_valid_r;
    assign flit_data  = flit_data_r;
    assign busy       = busy_r;

endmodule
